// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the ram2 access controller.
// Optional macro ADDR_CHECK_EN (used by mem_access_ctrl) enables range checking.
package mem_ctrl_pkg;

  localparam int unsigned BITS_DEF    = 32;
  localparam int unsigned RAMSIZE_DEF = 512;
  localparam int unsigned RD_LAT_MAX  = 4;
  localparam int unsigned CNT_W       = $clog2(RD_LAT_MAX);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Counter preload for a read latency; first wait cycle sees RD_LAT-1.
  function automatic logic [CNT_W-1:0] lat_load(input int unsigned rd_lat);
    return CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag; times the ram2 read latency.
module mem_lat_counter
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  // Saturates at zero so an extra decrement request is harmless.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_count  = r_cnt;
  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store initiator for the ram2 synchronous memory.
// Define ADDR_CHECK_EN to reject addresses >= RAMSIZE with resp_err instead of wrapping.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BITS    = BITS_DEF,
  parameter int unsigned RAMSIZE = RAMSIZE_DEF,
  parameter int unsigned ADDR    = $clog2(RAMSIZE),
  parameter int unsigned RD_LAT  = 1
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [BITS-1:0] req_addr,
  input  logic [BITS-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [BITS-1:0] resp_rdata,
  output logic            resp_err,
  output logic [BITS-1:0] ram_dataIn,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_address,
  input  logic [BITS-1:0] ram_dataOut
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_req_ready;
  logic              w_req_ready_nxt;
  logic              r_resp_valid;
  logic              w_resp_valid_nxt;
  logic [BITS-1:0]   r_resp_rdata;
  logic [BITS-1:0]   w_resp_rdata_nxt;
  logic              r_resp_err;
  logic              w_resp_err_nxt;
  logic              r_ram_read;
  logic              w_ram_read_nxt;
  logic              r_ram_write;
  logic              w_ram_write_nxt;
  logic [ADDR-1:0]   r_ram_address;
  logic [ADDR-1:0]   w_addr_nxt;
  logic [BITS-1:0]   r_ram_dataIn;
  logic [BITS-1:0]   w_din_nxt;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_zero;
  logic              w_cnt_load;
  logic              w_cnt_dec;
  logic              w_oor;

`ifdef ADDR_CHECK_EN
  assign w_oor = (req_addr >= BITS'(RAMSIZE));
`else
  // Addresses wrap onto the low ADDR bits; the high bits are deliberately dropped.
  logic w_addr_hi_unused;
  assign w_oor            = 1'b0;
  assign w_addr_hi_unused = |req_addr[BITS-1:ADDR];
`endif

  mem_lat_counter #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk        (clk),
    .clr        (clr),
    .i_load     (w_cnt_load),
    .i_load_val (lat_load(RD_LAT)),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_zero_c   (w_cnt_zero)
  );

  // Next-state and next-output logic; RAM strobes are computed one cycle ahead
  // so they leave the block registered.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = r_req_ready;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    w_ram_read_nxt   = 1'b0;
    w_ram_write_nxt  = 1'b0;
    w_addr_nxt       = r_ram_address;
    w_din_nxt        = r_ram_dataIn;
    w_cnt_load       = 1'b0;
    w_cnt_dec        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready_nxt  = 1'b0;
          w_addr_nxt       = req_addr[ADDR-1:0];
          w_din_nxt        = req_wdata;
          w_resp_rdata_nxt = '0;
          w_resp_err_nxt   = 1'b0;
          if (w_oor) begin
            w_state_nxt    = ST_RESP;
            w_resp_err_nxt = 1'b1;
          end else if (req_write) begin
            w_state_nxt     = ST_WRITE;
            w_ram_write_nxt = 1'b1;
          end else begin
            w_state_nxt    = ST_READ;
            w_ram_read_nxt = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        w_state_nxt = ST_RESP;
      end

      ST_READ: begin
        w_cnt_load     = 1'b1;
        w_ram_read_nxt = (RD_LAT > 1);
        w_state_nxt    = ST_RWAIT;
      end

      // Read strobe lasts RD_LAT cycles; data is captured once the count expires.
      ST_RWAIT: begin
        w_cnt_dec = 1'b1;
        if (w_cnt_zero) begin
          w_resp_rdata_nxt = ram_dataOut;
          w_state_nxt      = ST_RESP;
        end else begin
          w_ram_read_nxt = (w_cnt > CNT_W'(1));
        end
      end

      ST_RESP: begin
        w_resp_valid_nxt = 1'b1;
        if (r_resp_valid && resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_req_ready_nxt  = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt      = ST_IDLE;
        w_req_ready_nxt  = 1'b1;
        w_resp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_rdata  <= '0;
      r_resp_err    <= 1'b0;
      r_ram_read    <= 1'b0;
      r_ram_write   <= 1'b0;
      r_ram_address <= '0;
      r_ram_dataIn  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_resp_valid  <= w_resp_valid_nxt;
      r_resp_rdata  <= w_resp_rdata_nxt;
      r_resp_err    <= w_resp_err_nxt;
      r_ram_read    <= w_ram_read_nxt;
      r_ram_write   <= w_ram_write_nxt;
      r_ram_address <= w_addr_nxt;
      r_ram_dataIn  <= w_din_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign ram_read    = r_ram_read;
  assign ram_write   = r_ram_write;
  assign ram_address = r_ram_address;
  assign ram_dataIn  = r_ram_dataIn;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (RD_LAT 1 and 3) share stimulus, each with its own ram2 model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  logic [1:0]  req_ready_a;
  logic [1:0]  resp_valid_a;
  logic [1:0]  resp_err_a;
  logic [1:0]  ram_read_a;
  logic [1:0]  ram_write_a;
  logic [31:0] resp_rdata_a  [2];
  logic [31:0] ram_dataIn_a  [2];
  logic [31:0] ram_dataOut_a [2];
  logic [8:0]  ram_address_a [2];

  int checks = 0;
  int errors = 0;
  int rd_cnt [2] = '{0, 0};
  int wr_cnt [2] = '{0, 0};
  int both_cnt [2] = '{0, 0};
  logic [31:0] ref_mem [512];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h0000_9E37) ^ 32'h5A5A_0000;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned LAT = (g == 0) ? 1 : 3;
    logic [31:0] ram   [512];
    logic [31:0] dpipe [4];

    mem_access_ctrl #(
      .BITS    (32),
      .RAMSIZE (512),
      .RD_LAT  (LAT)
    ) u_dut (
      .clk         (clk),
      .clr         (clr),
      .req_valid   (req_valid),
      .req_ready   (req_ready_a[g]),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid_a[g]),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata_a[g]),
      .resp_err    (resp_err_a[g]),
      .ram_dataIn  (ram_dataIn_a[g]),
      .ram_read    (ram_read_a[g]),
      .ram_write   (ram_write_a[g]),
      .ram_address (ram_address_a[g]),
      .ram_dataOut (ram_dataOut_a[g])
    );

    initial begin
      for (int i = 0; i < 512; i++) ram[i] = init_val(i);
      for (int i = 0; i < 4; i++) dpipe[i] = 32'hDEAD_BEEF;
    end

    // ram2 model: data appears LAT cycles after read is raised, garbage otherwise.
    always @(posedge clk) begin
      if (ram_write_a[g]) ram[ram_address_a[g]] <= ram_dataIn_a[g];
      dpipe[0] <= ram_read_a[g] ? ram[ram_address_a[g]] : 32'hDEAD_BEEF;
      for (int i = 1; i < 4; i++) dpipe[i] <= dpipe[i-1];
    end
    assign ram_dataOut_a[g] = dpipe[LAT-1];
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_read_a[k]) rd_cnt[k]++;
      if (ram_write_a[k]) wr_cnt[k]++;
      if (ram_read_a[k] && ram_write_a[k]) both_cnt[k]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on both instances; hold>0 applies backpressure and offers an extra request.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    int          exp_lat [2];
    int          rd0 [2];
    int          wr0 [2];
    bit          seen [2];
    int          held;
    int          cyc;
    bit          oor;
    logic [31:0] eff;
    logic [31:0] exp_rd;
    eff = a % 32'd512;
    oor = 1'b0;
`ifdef ADDR_CHECK_EN
    oor = (a >= 32'd512);
`endif
    exp_rd = (w || oor) ? 32'd0 : ref_mem[eff[8:0]];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_lat[k] = oor ? 1 : (w ? 2 : lat_of(k) + 2);
      rd0[k] = rd_cnt[k];
      wr0[k] = wr_cnt[k];
      seen[k] = 1'b0;
      chk("req_ready_idle", 32'(req_ready_a[k]), 32'd1);
    end
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = (hold == 0);
    held = 0;
    cyc  = 0;
    @(negedge clk);
    if (hold == 0) begin
      req_valid = 1'b0;
    end else begin
      req_write = 1'b1;
      req_addr  = a + 32'd1;
      req_wdata = ~d;
    end
    forever begin
      for (int k = 0; k < 2; k++) begin
        if (resp_valid_a[k] && !seen[k]) begin
          seen[k] = 1'b1;
          chk("latency", 32'(cyc), 32'(exp_lat[k]));
          chk("rdata", resp_rdata_a[k], exp_rd);
          chk("err", 32'(resp_err_a[k]), 32'(oor));
        end
      end
      if (seen[0] && seen[1] && !resp_ready) begin
        for (int k = 0; k < 2; k++) begin
          chk("bp_valid", 32'(resp_valid_a[k]), 32'd1);
          chk("bp_rdata", resp_rdata_a[k], exp_rd);
          chk("bp_req_ready", 32'(req_ready_a[k]), 32'd0);
        end
        held++;
        if (held >= hold) resp_ready = 1'b1;
      end
      if (seen[0] && seen[1] && resp_ready) break;
      if (cyc >= 40) begin
        chk("resp_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("post_valid", 32'(resp_valid_a[k]), 32'd0);
      chk("post_req_ready", 32'(req_ready_a[k]), 32'd1);
      chk("rd_cycles", 32'(rd_cnt[k] - rd0[k]), (!w && !oor) ? 32'(lat_of(k)) : 32'd0);
      chk("wr_cycles", 32'(wr_cnt[k] - wr0[k]), (w && !oor) ? 32'd1 : 32'd0);
      if (!oor) chk("ram_address", 32'(ram_address_a[k]), eff);
      if (w && !oor) chk("ram_dataIn", ram_dataIn_a[k], d);
    end
    if (w && !oor) ref_mem[eff[8:0]] = d;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    clr        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_req_ready", 32'(req_ready_a[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid_a[k]), 32'd0);
      chk("rst_rdata", resp_rdata_a[k], 32'd0);
      chk("rst_err", 32'(resp_err_a[k]), 32'd0);
      chk("rst_ram_read", 32'(ram_read_a[k]), 32'd0);
      chk("rst_ram_write", 32'(ram_write_a[k]), 32'd0);
      chk("rst_ram_address", 32'(ram_address_a[k]), 32'd0);
      chk("rst_ram_dataIn", ram_dataIn_a[k], 32'd0);
    end
    clr = 1'b0;

    do_req(1'b1, 32'd3, 32'd5, 0);
    do_req(1'b0, 32'd3, 32'd0, 0);
    do_req(1'b0, 32'd3, 32'd0, 5);
    do_req(1'b0, 32'd4, 32'd0, 0);
    do_req(1'b0, 32'd600, 32'd0, 0);
    do_req(1'b1, 32'd600, 32'h0BAD_F00D, 0);
    do_req(1'b0, 32'd88, 32'd0, 0);
    do_req(1'b0, 32'd511, 32'd0, 0);
    do_req(1'b0, 32'd512, 32'd0, 0);

    // Reset while the RD_LAT=3 instance is waiting on the RAM.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_read_active", 32'(ram_read_a[1]), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_ram_read", 32'(ram_read_a[k]), 32'd0);
      chk("mid_rst_resp_valid", 32'(resp_valid_a[k]), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready_a[k]), 32'd1);
    end
    clr = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("mid_rst_no_resp", 32'(resp_valid_a[k]), 32'd0);

    for (int n = 0; n < 30; n++) begin
      logic        w;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(500, 700)) : 32'($urandom_range(0, 15));
      do_req(w, a, $urandom, int'($urandom_range(0, 2)));
    end

    for (int k = 0; k < 2; k++) chk("rw_exclusive", 32'(both_cnt[k]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the ram2 synchronous memory: the datapath/control unit (MAR/MDR side) issues single load/store requests over a valid/ready handshake. The block sequences ram2's dataIn/read/write/address pins, waits out the read latency, and returns read data or write completion on a response handshake. It sits between the bus architecture and ram2, one outstanding request at a time.

Parameters:
BITS, 32, data word width (matches ram2)
RAMSIZE, 512, number of RAM words
ADDR, $clog2(RAMSIZE), RAM address width
RD_LAT, 1, cycles from ram_read assertion to valid ram_dataOut (1..4)

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request (high only in IDLE)
req_write  in  1  1=store, 0=load
req_addr  in  BITS  word address from MAR
req_wdata  in  BITS  store data from MDR
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  BITS  load data (0 for stores/errors)
resp_err  out  1  address out of range (only with ADDR_CHECK_EN)
ram_dataIn  out  BITS  to ram2 dataIn
ram_read  out  1  to ram2 read
ram_write  out  1  to ram2 write
ram_address  out  ADDR  to ram2 address
ram_dataOut  in  BITS  from ram2 dataOut

Behaviour:
- Reset (clr high at clk edge): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; ram_read=0, ram_write=0, ram_address=0, ram_dataIn=0; latency counter=0. Reset mid-operation aborts immediately; a pending write pulse is dropped if not yet issued.
- States: IDLE, WRITE, READ, RWAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready at edge N: latch addr (low ADDR bits) and wdata into ram_address/ram_dataIn; goto WRITE if req_write else READ. Error path (see Optional Feature) goes straight to RESP.
- WRITE (cycle N+1): ram_write=1 for exactly one cycle; goto RESP with resp_rdata=0.
- READ (cycle N+1): ram_read=1, counter loaded with RD_LAT-1; goto RWAIT if RD_LAT>1 else capture ram_dataOut at end of next cycle via RWAIT with count 0.
- RWAIT: ram_read held 1; counter decrements; when counter==0, register ram_dataOut into resp_rdata, goto RESP.
- RESP: resp_valid=1, ram_read=ram_write=0, outputs stable until resp_valid&resp_ready; then IDLE (req_ready=1 next cycle, no back-to-back accept in the RESP exit cycle).
- Latency req accept -> resp_valid: store 2 cycles; load RD_LAT+2 cycles.
- ram_read and ram_write never both high. ram_address/ram_dataIn held constant from accept until return to IDLE.
- req_valid while not IDLE ignored (req_ready=0). resp_ready held high: single-cycle response.

Optional Feature:
ADDR_CHECK_EN: defined -> request with req_addr >= RAMSIZE yields no RAM access; next cycle RESP with resp_err=1, resp_rdata=0 (1-cycle latency). Undefined -> req_addr truncated to low ADDR bits (wraps, e.g. 515 -> 3), resp_err tied 0.

Decomposition:
- Package mem_ctrl_pkg: state enumeration (IDLE/WRITE/READ/RWAIT/RESP), default BITS/RAMSIZE constants, RD_LAT max (4).
- Sub-module mem_lat_counter: loadable down-counter with zero flag for RD_LAT wait; remainder in mem_access_ctrl.

Test Plan:
- Reset: clr high 2 cycles -> all outputs 0, req_ready=1, state IDLE.
- Store: req addr=3, wdata=5, write=1 -> ram_write pulse 1 cycle with address 3, dataIn 5; resp_valid 2 cycles after accept, resp_rdata=0.
- Load after store: read addr=3 with RD_LAT=1 then RD_LAT=3 -> ram_read high RD_LAT cycles, resp_rdata=5 at RD_LAT+2 cycles.
- Backpressure: resp_ready=0 for 5 cycles on load of addr 3 -> resp_valid/resp_rdata=5 held, req_ready=0, second req_valid ignored until handshake.
- Out-of-range addr 600: with ADDR_CHECK_EN -> resp_err=1, no ram_read/ram_write; without -> access to addr 88 (600 mod 512).
- Reset mid-load (clr in RWAIT, RD_LAT=3) -> ram_read drops next edge, no resp_valid, req_ready=1.
